// File: rtl/fft_frame_arbiter.sv
// fft_frame_arbiter: round-robin whole-frame arbiter feeding one fft64 core from two sources,
// with a source-ID tag FIFO that labels the core's output frames.
module fft_frame_arbiter #(
    parameter int FRAME_LEN = 64,
    parameter int W         = 11,
    parameter int TAG_DEPTH = 4,
    parameter int GAP       = 1
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                req0,
    output logic                                gnt0,
    input  logic                                valid0,
    input  logic signed [W-1:0]                 ar0,
    input  logic signed [W-1:0]                 ai0,
    input  logic                                req1,
    output logic                                gnt1,
    input  logic                                valid1,
    input  logic signed [W-1:0]                 ar1,
    input  logic signed [W-1:0]                 ai1,
    output logic                                core_valid_a,
    output logic signed [W-1:0]                 core_ar,
    output logic signed [W-1:0]                 core_ai,
    input  logic                                core_valid_o,
    input  logic signed [W-1:0]                 core_xr,
    input  logic signed [W-1:0]                 core_xi,
    output logic                                out_valid,
    output logic signed [W-1:0]                 out_xr,
    output logic signed [W-1:0]                 out_xi,
    output logic                                out_id,
    output logic                                out_first,
    output logic                                out_last,
    output logic                                busy,
    output logic [$clog2(TAG_DEPTH+1)-1:0]      in_flight,
    output logic                                err_gap,
    output logic                                err_orphan
);
    localparam int IW = $clog2(FRAME_LEN);
    localparam int CW = $clog2(TAG_DEPTH + 1);
    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int GW = $clog2(GAP + 2);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_STREAM, S_GAP} state_t;

    state_t               state_q, state_d;
    logic                 win_q, win_d, last_q, last_d;
    logic [IW-1:0]        idx_q, idx_d, ocnt_q;
    logic [GW-1:0]        gcnt_q, gcnt_d;
    logic [TAG_DEPTH-1:0] tag_q;
    logic [PW-1:0]        wp_q, rp_q;
    logic [CW-1:0]        cnt_q;
    logic                 push, pop, empty, stream, src_valid;
    logic signed [W-1:0]  src_ar, src_ai, car_q, cai_q, oxr_q, oxi_q;
    logic                 cva_q, ov_q, oid_q, ofirst_q, olast_q, egap_q, eorph_q;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(TAG_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        last_d  = last_q;
        idx_d   = idx_q;
        gcnt_d  = gcnt_q;
        push    = 1'b0;
        case (state_q)
            S_IDLE: if ((req0 || req1) && cnt_q < CW'(TAG_DEPTH)) begin
                state_d = S_GRANT;
                // on a tie the requester not served last wins
                win_d   = (req0 && req1) ? !last_q : req1;
            end
            S_GRANT: begin
                push    = 1'b1;
                last_d  = win_q;
                idx_d   = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == IW'(FRAME_LEN - 1)) begin
                    state_d = (GAP == 0) ? S_IDLE : S_GAP;
                    gcnt_d  = '0;
                end
            end
            S_GAP: begin
                gcnt_d = gcnt_q + 1'b1;
                if (gcnt_q == GW'(GAP - 1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            win_q   <= 1'b0;
            last_q  <= 1'b1;
            idx_q   <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            gcnt_q  <= gcnt_d;
        end
    end

    assign stream    = state_q == S_STREAM;
    assign src_valid = win_q ? valid1 : valid0;
    assign src_ar    = win_q ? ar1 : ar0;
    assign src_ai    = win_q ? ai1 : ai0;
    assign empty     = cnt_q == '0;
    assign pop       = core_valid_o && !empty && ocnt_q == IW'(FRAME_LEN - 1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tag_q    <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
            ocnt_q   <= '0;
            cva_q    <= 1'b0;
            car_q    <= '0;
            cai_q    <= '0;
            ov_q     <= 1'b0;
            oxr_q    <= '0;
            oxi_q    <= '0;
            oid_q    <= 1'b0;
            ofirst_q <= 1'b0;
            olast_q  <= 1'b0;
            egap_q   <= 1'b0;
            eorph_q  <= 1'b0;
        end else begin
            if (push) tag_q[wp_q] <= win_q;
            wp_q     <= push ? nxt(wp_q) : wp_q;
            rp_q     <= pop ? nxt(rp_q) : rp_q;
            cnt_q    <= cnt_q + CW'(push) - CW'(pop);
            // a dropped source sample is replaced by zero so the core still sees a contiguous frame
            cva_q    <= stream;
            car_q    <= (stream && src_valid) ? src_ar : '0;
            cai_q    <= (stream && src_valid) ? src_ai : '0;
            egap_q   <= egap_q || (stream && !src_valid);
            ocnt_q   <= ocnt_q + IW'(core_valid_o);
            ov_q     <= core_valid_o;
            oxr_q    <= core_xr;
            oxi_q    <= core_xi;
            oid_q    <= !empty && tag_q[rp_q];
            ofirst_q <= core_valid_o && ocnt_q == '0;
            olast_q  <= core_valid_o && ocnt_q == IW'(FRAME_LEN - 1);
            eorph_q  <= eorph_q || (core_valid_o && empty);
        end
    end

    assign gnt0         = state_q == S_GRANT && !win_q;
    assign gnt1         = state_q == S_GRANT && win_q;
    assign busy         = state_q != S_IDLE;
    assign in_flight    = cnt_q;
    assign core_valid_a = cva_q;
    assign core_ar      = car_q;
    assign core_ai      = cai_q;
    assign out_valid    = ov_q;
    assign out_xr       = oxr_q;
    assign out_xi       = oxi_q;
    assign out_id       = oid_q;
    assign out_first    = ofirst_q;
    assign out_last     = olast_q;
    assign err_gap      = egap_q;
    assign err_orphan   = eorph_q;
endmodule

// File: tb/tb_fft_frame_arbiter.sv
// tb_fft_frame_arbiter: directed bench; the bench plays both sources and a pass-through fft core,
// and checks every cycle against a frame-level model of grants, tags and sample streams.
module tb_fft_frame_arbiter;
    localparam int N = 64, W = 11, TD = 4, GAP = 1, CW = $clog2(TD + 1);

    logic clk = 1'b0, rst_n = 1'b0;
    logic [1:0] req = '0, vld = '0;
    logic signed [W-1:0] ar[2], ai[2];
    logic gnt0, gnt1, cva, ov, oid, ofirst, olast, busy, eg, eo;
    logic signed [W-1:0] car, cai, oxr, oxi;
    logic cvo = 1'b0;
    logic signed [W-1:0] cxr = '0, cxi = '0;
    logic [CW-1:0] inf;

    fft_frame_arbiter dut (
        .CLK(clk), .RST(rst_n),
        .req0(req[0]), .gnt0(gnt0), .valid0(vld[0]), .ar0(ar[0]), .ai0(ai[0]),
        .req1(req[1]), .gnt1(gnt1), .valid1(vld[1]), .ar1(ar[1]), .ai1(ai[1]),
        .core_valid_a(cva), .core_ar(car), .core_ai(cai),
        .core_valid_o(cvo), .core_xr(cxr), .core_xi(cxi),
        .out_valid(ov), .out_xr(oxr), .out_xi(oxi), .out_id(oid),
        .out_first(ofirst), .out_last(olast), .busy(busy), .in_flight(inf),
        .err_gap(eg), .err_orphan(eo)
    );

    always #5 clk = ~clk;

    int checks = 0, passed = 0;
    int want[2] = '{0, 0};
    bit drop1 = 1'b0, orphan_req = 1'b0;
    int budget = 1000000;
    int ein_r[$], ein_i[$], cq_r[$], cq_i[$], oq_r[$], oq_i[$];
    bit ein_d[$], tq[$];
    int gnt_log[$], oid_log[$];
    time gnt_t[$];
    time last_t = 0;
    int last_xr = 0, n_out = 0, n_zero = 0, mcnt = 0, run = 0, idle = 1000;
    bit exp_gap = 0, exp_orph = 0, last_srv = 1, prev_gnt = 0, prev_cvo = 0;
    logic [1:0] prev_req = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // source: wait for a frame slot, then stream a ramp starting the cycle after gnt
    task automatic source(input int id);
        int base = id * 100;
        bit d;
        forever begin
            wait (want[id] > 0 && rst_n);
            @(posedge clk); #1;
            req[id] = 1'b1;
            do @(negedge clk); while (rst_n && !(id == 1 ? gnt1 : gnt0));
            if (rst_n)
                for (int i = 0; i < N; i++) begin
                    @(posedge clk); #1;
                    req[id] = 1'b0;
                    if (!rst_n) break;
                    d = drop1 && id == 1 && i >= 10 && i < 13;
                    vld[id] = !d;
                    ar[id] = d ? W'(555) : W'(base + i);
                    ai[id] = d ? W'(-555) : W'(-(base + i));
                    ein_r.push_back(d ? 0 : base + i);
                    ein_i.push_back(d ? 0 : -(base + i));
                    ein_d.push_back(d);
                end
            if (rst_n) begin @(posedge clk); #1; end
            req[id] = 1'b0;
            vld[id] = 1'b0;
            ar[id] = W'(333);
            ai[id] = W'(-333);
            if (!rst_n) want[id] = 0;
            else if (want[id] > 0) want[id]--;
        end
    endtask

    initial begin ar[0] = '0; ai[0] = '0; source(0); end
    initial begin ar[1] = '0; ai[1] = '0; source(1); end

    // pass-through core: replays captured input samples when allowed, or a lone orphan sample
    initial forever begin
        @(posedge clk); #1;
        if (rst_n && budget > 0 && cq_r.size() > 0) begin
            cvo = 1'b1;
            cxr = W'(cq_r.pop_front());
            cxi = W'(cq_i.pop_front());
            oq_r.push_back(int'(cxr));
            oq_i.push_back(int'(cxi));
            budget--;
        end else if (rst_n && orphan_req) begin
            cvo = 1'b1;
            cxr = W'(77);
            cxi = W'(-77);
            oq_r.push_back(77);
            oq_i.push_back(-77);
            orphan_req = 1'b0;
        end else cvo = 1'b0;
    end

    always @(negedge rst_n) begin
        ein_r.delete(); ein_i.delete(); ein_d.delete();
        cq_r.delete(); cq_i.delete(); oq_r.delete(); oq_i.delete(); tq.delete();
        exp_gap = 0; exp_orph = 0; last_srv = 1; prev_gnt = 0; prev_cvo = 0;
        prev_req = '0; mcnt = 0; run = 0; idle = 1000;
    end

    always @(negedge clk) if (rst_n) begin
        int e_id;
        bit e_last;
        chk("out_valid", ov, prev_cvo);
        if (ov) begin
            n_out++;
            chk("out_pending", int'(oq_r.size() > 0), 1);
            if (oq_r.size() > 0) begin
                chk("out_xr", oxr, oq_r.pop_front());
                chk("out_xi", oxi, oq_i.pop_front());
            end
            e_last = mcnt == N - 1;
            e_id = tq.size() > 0 ? int'(tq[0]) : 0;
            if (tq.size() == 0) exp_orph = 1;
            chk("out_id", oid, e_id);
            chk("out_first", ofirst, int'(mcnt == 0));
            chk("out_last", olast, int'(e_last));
            if (ofirst) oid_log.push_back(oid);
            if (e_last) begin
                last_t = $time;
                last_xr = oxr;
                if (tq.size() > 0) void'(tq.pop_front());
            end
            mcnt = (mcnt + 1) % N;
        end
        chk("err_orphan", eo, exp_orph);
        if (cva) begin
            chk("in_pending", int'(ein_r.size() > 0), 1);
            if (ein_r.size() > 0) begin
                chk("core_ar", car, ein_r.pop_front());
                chk("core_ai", cai, ein_i.pop_front());
                if (ein_d.pop_front()) exp_gap = 1;
            end
            if (car == 0 && cai == 0) n_zero++;
            cq_r.push_back(int'(car));
            cq_i.push_back(int'(cai));
            if (run == 0) chk("frame_spacing", int'(idle >= GAP + 2), 1);
            run++;
            idle = 0;
        end else begin
            if (run > 0) chk("frame_len", run, N);
            run = 0;
            idle++;
        end
        chk("err_gap", eg, exp_gap);
        chk("in_flight", inf, tq.size());
        if (gnt0 || gnt1) begin
            chk("gnt_onehot", int'(gnt0 && gnt1), 0);
            chk("gnt_pulse", prev_gnt, 0);
            chk("gnt_requested", prev_req[gnt1], 1);
            chk("gnt_winner", gnt1, prev_req == 2'b11 ? int'(!last_srv) : int'(prev_req[1]));
            chk("gnt_room", int'(tq.size() < TD), 1);
            chk("busy_grant", busy, 1);
            tq.push_back(gnt1);
            last_srv = gnt1;
            gnt_log.push_back(gnt1);
            gnt_t.push_back($time);
        end
        prev_gnt = gnt0 || gnt1;
        prev_req = req;
        prev_cvo = cvo;
    end

    task automatic do_reset();
        @(negedge clk); #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        gnt_log.delete(); gnt_t.delete(); oid_log.delete();
        n_out = 0; n_zero = 0;
    endtask

    task automatic wait_grants(input int n, input int lim);
        for (int i = 0; i < lim && gnt_log.size() < n; i++) begin @(negedge clk); #1; end
        chk("grant_wait", int'(gnt_log.size() >= n), 1);
    endtask

    task automatic wait_idle(input int lim);
        bit done = 0;
        for (int i = 0; i < lim && !done; i++) begin
            @(negedge clk); #1;
            done = want[0] == 0 && want[1] == 0 && req == 0 && !busy && tq.size() == 0 &&
                   cq_r.size() == 0 && oq_r.size() == 0;
        end
        repeat (5) @(negedge clk);
        #1 chk("idle_wait", int'(done), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_gnt", int'(gnt0 || gnt1), 0);
        chk("rst_core_valid", cva, 0);
        chk("rst_out_valid", ov, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_flight", inf, 0);
        chk("rst_errs", int'(eg || eo), 0);
        #1 rst_n = 1'b1;

        want[0] = 1;
        wait_grants(1, 50);
        @(negedge clk); #1 chk("t1_in_flight_1", inf, 1);
        wait_idle(1000);
        chk("t1_grants", gnt_log.size(), 1);
        chk("t1_outs", n_out, 64);
        chk("t1_id", oid_log[0], 0);
        chk("t1_last_xr", last_xr, 63);
        chk("t1_in_flight_0", inf, 0);

        do_reset();
        want[0] = 2;
        want[1] = 2;
        wait_idle(2000);
        chk("t2_grants", gnt_log.size(), 4);
        foreach (gnt_log[k]) chk("t2_order", gnt_log[k], k % 2);
        foreach (oid_log[k]) chk("t2_out_id", oid_log[k], k % 2);
        chk("t2_outs", n_out, 256);

        do_reset();
        budget = 0;
        want[0] = 6;
        wait_grants(4, 2000);
        repeat (200) @(negedge clk);
        #1;
        chk("t3_stalled_grants", gnt_log.size(), 4);
        chk("t3_in_flight_full", inf, 4);
        chk("t3_busy_blocked", busy, 0);
        budget = 64;
        wait_grants(5, 500);
        chk("t3_grant_after_last", int'(gnt_t[4] > last_t && last_t > gnt_t[3]), 1);
        budget = 1000000;
        wait_idle(3000);
        chk("t3_total_grants", gnt_log.size(), 6);
        chk("t3_outs", n_out, 6 * 64);

        do_reset();
        drop1 = 1'b1;
        want[1] = 1;
        wait_idle(1000);
        drop1 = 1'b0;
        chk("t4_err_gap", eg, 1);
        chk("t4_zero_samples", n_zero, 3);
        want[0] = 1;
        wait_idle(1000);
        chk("t4_err_gap_sticky", eg, 1);
        chk("t4_id", oid_log[1], 0);

        orphan_req = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("t5_err_orphan", eo, 1);
        chk("t5_in_flight", inf, 0);
        chk("t5_out_id", oid, 0);

        want[0] = 1;
        for (int i = 0; i < 200 && !(cva && car == 30); i++) begin @(negedge clk); #1; end
        chk("t6_reached_30", int'(cva && car == 30), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_core_cleared", int'(cva || car != 0 || cai != 0), 0);
        chk("t6_out_cleared", int'(ov || ofirst || olast || oid || oxr != 0), 0);
        chk("t6_state_cleared", int'(busy || gnt0 || gnt1), 0);
        chk("t6_in_flight", inf, 0);
        chk("t6_errs_cleared", int'(eg || eo), 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        gnt_log.delete(); oid_log.delete(); n_out = 0;
        want[0] = 1;
        wait_grants(1, 50);
        @(negedge clk); #1 chk("t6_in_flight_1", inf, 1);
        wait_idle(1000);
        chk("t6_outs", n_out, 64);
        chk("t6_id", oid_log[0], 0);
        chk("t6_no_errs", int'(eg || eo), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/fft_frame_arbiter.md
Name: fft_frame_arbiter

Overview:
Shares one fft64 core between two sample sources (requesters 0 and 1). Grants whole 64-sample frames round-robin and streams the granted source's samples into the core as a contiguous burst. Tags every frame with its source ID in a small FIFO, then labels the core's output frames with that ID, a start marker and a last marker. Sits between the capture front-ends and fft64; the core's valid_a/ar/ai inputs and valid_o/xr/xi outputs connect directly to this block.

Parameters:
FRAME_LEN, 64, samples per frame; must match the core size; power of two.
W, 11, signed sample width (real and imaginary).
TAG_DEPTH, 4, maximum frames in flight inside the core (tag FIFO depth).
GAP, 1, minimum idle cycles between the last sample of one frame and the next grant (0 allowed).

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-low
req0  in  1  requester 0 wants a frame slot; held high until gnt0
gnt0  out  1  one-cycle grant pulse to requester 0
valid0  in  1  requester 0 sample strobe
ar0, ai0  in  W each  requester 0 sample, signed
req1, gnt1, valid1, ar1, ai1  as for requester 0
core_valid_a  out  1  to fft64 valid_a
core_ar, core_ai  out  W each  to fft64 ar/ai
core_valid_o  in  1  from fft64 valid_o
core_xr, core_xi  in  W each  from fft64 xr/xi
out_valid  out  1  result sample valid
out_xr, out_xi  out  W each  result sample
out_id  out  1  source of the current result frame
out_first, out_last  out  1 each  result index 0 / index FRAME_LEN-1
busy  out  1  state != IDLE
in_flight  out  clog2(TAG_DEPTH+1)  tag FIFO occupancy
err_gap  out  1  sticky: valid dropped mid-frame
err_orphan  out  1  sticky: core output arrived with no tag

Behaviour:
- Reset (RST=0, async): all outputs 0, FSM=IDLE, counters 0, tag FIFO empty, round-robin pointer set so requester 0 wins the first tie. Both error flags clear. Nothing else clears them.
- Input FSM states: IDLE, GRANT, STREAM, GAP.
- IDLE -> GRANT when any req is high and in_flight < TAG_DEPTH. Winner: the only requester, or on a tie the one not served last.
- In GRANT, the winner's gnt is high for exactly 1 cycle. The winner's ID is pushed to the tag FIFO. The FSM then moves to STREAM with idx=0.
- STREAM lasts exactly FRAME_LEN cycles; idx counts 0..FRAME_LEN-1.
  - The requester's first sample is due the cycle after gnt.
  - Samples are registered: a sample on the source at cycle t appears on core_* at t+1 with core_valid_a=1.
  - If the source's valid is low during any STREAM cycle: a zero sample is still forwarded with core_valid_a=1, so the frame stays contiguous, and err_gap is set.
  - Requester data is ignored outside STREAM.
- After idx=FRAME_LEN-1: go to GAP for GAP cycles, then IDLE. With GAP=0, go straight to IDLE. The first core_valid_a of the next frame therefore follows at least GAP+2 cycles later (grant plus register).
- A full tag FIFO blocks grants only. A frame already in STREAM always completes.
- Output side, independent of the FSM:
  - A counter ocnt increments modulo FRAME_LEN on each core_valid_o.
  - out_* is registered one cycle after core_*.
  - out_id = tag FIFO head (show-ahead). out_first=1 when ocnt=0. out_last=1 when ocnt=FRAME_LEN-1.
  - The tag is popped on the last sample.
  - Push and pop in the same cycle is legal: occupancy stays unchanged.
  - core_valid_o while the FIFO is empty sets err_orphan and gives out_id=0. Nothing is popped.
- in_flight = FIFO count. It increments on GRANT and decrements on the pop.
- Reset mid-frame: the core shares RST, so all in-flight frames are discarded. There is no partial output after reset.

Test Plan:
- Single frame: req0 held, ramp ar0=i, ai0=-i for i=0..63 -> gnt0 exactly 1 cycle; core_ar = 0..63 on 64 consecutive core_valid_a cycles; outputs: 64 out_valid with out_id=0, out_first on the 1st, out_last on the 64th; in_flight 0->1->0.
- Tie and round-robin: req0 and req1 high from reset -> grant order 0,1,0,1; frames separated by >= GAP+1 idle core_valid_a cycles; out_id sequence 0,1,0,1.
- Backpressure: keep core_valid_o low, request continuously -> exactly 4 grants, then in_flight=4 and no gnt. Release one output frame -> the 5th grant occurs after out_last.
- Gap error: drop valid1 at sample 10 for 3 cycles -> core_valid_a stays high, core_ar/ai=0 for those 3 samples, err_gap=1 and remains 1 until RST.
- Orphan: pulse core_valid_o with FIFO empty -> err_orphan=1, out_id=0, in_flight stays 0.
- Reset mid-STREAM at sample 30 -> all outputs 0 immediately (async); after release, a new req0 is granted cleanly with in_flight starting from 0.
